// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, types and saturating-add helper for the MAC accumulator
package mac_pkg;

  localparam int ACC_W = 40;
  localparam int PROD_W = 32;

  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  // Returns {overflow, result}; overflow is only reported when saturating.
  function automatic logic [ACC_W:0] sat_add(acc_t a, acc_t b, bit saturate);
    acc_t raw;
    logic ovf;
    raw = a + b;
    ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
    if (saturate && ovf) begin
      raw = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return {saturate && ovf, raw};
  endfunction

endpackage

// File: rtl/mac_sat_adder.sv
// rtl/mac_sat_adder.sv - combinational signed add with overflow detect and optional clamp
module mac_sat_adder #(
  parameter int ACC_W    = 40,
  parameter bit SATURATE = 1'b1
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    sat
);

  logic signed [ACC_W-1:0] raw;
  logic                    ovf;

  assign raw = a + b;
  assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

  always_comb begin
    sum = raw;
    sat = 1'b0;
    // In wrap mode overflow is intentional and never reported.
    if (SATURATE && ovf) begin
      sat = 1'b1;
      sum = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - final CPA of the multiplier Sum/Carry pair plus dot-product accumulator
module mac_accumulator #(
  parameter int ACC_W    = mac_pkg::ACC_W,
  parameter bit SATURATE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_sum,
  input  logic [31:0]             in_carry,
  input  logic                    in_last,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_sat
);

  import mac_pkg::*;

  logic                    s1_valid;
  logic                    s1_last;
  prod_t                   s1_p;
  logic signed [ACC_W-1:0] acc;
  logic                    sat_sticky;

  logic                    s1_advance;
  logic                    in_fire;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] nxt;
  logic                    beat_sat;

  // Only a last beat can be blocked, and only by an unconsumed result.
  assign s1_advance = s1_valid && !(s1_last && out_valid && !out_ready);
  assign in_ready   = !s1_valid || s1_advance;
  assign in_fire    = in_valid && in_ready;
  assign p_ext      = {{(ACC_W-32){s1_p[31]}}, s1_p};

  mac_sat_adder #(
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_add (
    .a   (acc),
    .b   (p_ext),
    .sum (nxt),
    .sat (beat_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_p       <= '0;
      acc        <= '0;
      sat_sticky <= 1'b0;
    end else if (flush) begin
      s1_valid   <= 1'b0;
      acc        <= '0;
      sat_sticky <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_last  <= in_last;
        s1_p     <= prod_t'(in_sum + in_carry);
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
      if (s1_advance) begin
        if (s1_last) begin
          acc        <= '0;
          sat_sticky <= 1'b0;
        end else begin
          acc        <= nxt;
          sat_sticky <= sat_sticky | beat_sat;
        end
      end
    end
  end

  // Result register; a consumed result may be replaced on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (!flush && s1_advance && s1_last) begin
        out_valid <= 1'b1;
        out_data  <= nxt;
        out_sat   <= sat_sticky | beat_sat;
      end
    end
  end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Sits directly downstream of the combinational Booth/Wallace multiplier and consumes its 32-bit redundant Sum/Carry pair.
- Performs the final carry-propagate add, sign-extends the 16x16 signed product, and accumulates a stream of products into a wide signed accumulator for dot-product use.
- Accumulation is optionally saturating.
- Valid/ready handshakes are used on both sides. The final accumulated value is emitted on the beat flagged last.

Parameters:
- ACC_W, 40: accumulator and output width in bits (must be at least 33).
- SATURATE, 1: 1 = clamp on signed overflow, 0 = wrap modulo 2^ACC_W.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  Sum/Carry/in_last are valid.
- in_ready  output  1  block accepts the input beat this cycle.
- in_sum  input  32  tree Sum vector.
- in_carry  input  32  tree Carry vector (already aligned, no shift applied here).
- in_last  input  1  beat is the final term of the current dot product.
- flush  input  1  synchronous clear of pipeline and accumulator.
- out_valid  output  1  out_data/out_sat hold a completed result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  ACC_W  signed accumulated result.
- out_sat  output  1  saturation occurred at least once during this dot product.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Stage-1 valid, accumulator, sticky sat, out_valid, out_data and out_sat all go to 0.
  - in_ready is 1 immediately after reset.
- Stage 1 (register):
  - On a handshake (in_valid && in_ready), capture p = (in_sum + in_carry) mod 2^32, plus last, into s1.
  - p is interpreted as signed 32-bit.
- Stage 2 (accumulate):
  - When s1 is valid and may advance, compute nxt = acc + sign_extend(p, ACC_W).
  - Overflow occurs when both operand signs match and the result sign differs.
  - SATURATE=1: on overflow, clamp to 2^(ACC_W-1)-1 (positive) or -2^(ACC_W-1) (negative) and set sat_sticky.
  - SATURATE=0: nxt wraps and sat_sticky is never set.
- s1 not last: acc <= nxt.
- s1 last:
  - out_data <= nxt and out_sat <= sat_sticky OR this-beat overflow.
  - out_valid <= 1.
  - acc <= 0 and sat_sticky <= 0, so the next dot product starts clean.
- Latency: a beat accepted at edge N is in s1 after N. Its contribution lands in acc/out at edge N+1. out_valid is high in the cycle after that edge.
- Single-beat dot products (in_last on every beat) are legal and yield out_data = sign-extended product.
- Stall rule:
  - s1 advances unless (s1.last && out_valid && !out_ready).
  - in_ready = !s1_valid || s1_advance.
  - Non-last beats never stall on the output. A full rate of 1 beat/cycle is sustained while out_ready=1.
- Output handshake:
  - out_valid && out_ready clears out_valid at the edge, unless a new last beat loads in the same cycle. In that case out_valid stays 1 with the new data.
  - out_data and out_sat are stable while out_valid && !out_ready.
- flush (sync, highest priority after reset):
  - Clears s1_valid, acc and sat_sticky.
  - Does not touch out_valid/out_data/out_sat, so a pending result survives.
  - An input handshake in the flush cycle is discarded.
- in_valid low: no state change in stage 1. A stalled s1 holds its value.
- Wrap of the 32-bit product is intentional: the tree delivers a two's-complement product in 32 bits.

Decomposition:
- Shared package mac_pkg holds:
  - ACC_W default constant.
  - Typedef acc_t (logic signed [ACC_W-1:0]).
  - Typedef prod_t (logic signed [31:0]).
  - Function sat_add(acc_t, acc_t, bit) returning {overflow, result}.
- One natural sub-module: mac_sat_adder, the combinational ACC_W signed add with overflow detect and clamp.
- Stage regs and handshake logic stay in the top module.

Test Plan:
- Single-term product: sum=0x00000006, carry=0x0000000C, last=1 -> out_data=0x0000000012, out_sat=0, out_valid high 2 cycles after acceptance.
- Two-term dot product:
  - Beat 1: sum=0x12, carry=0 (18).
  - Beat 2: sum=0xFFFFFFF0, carry=0x0000000C (-4), last=1.
  - Expected: out_data=0x000000000E. A third single beat of 5 then gives out_data=0x0000000005, confirming the accumulator was cleared.
- Saturation: 512 beats of sum=0x40000000, carry=0 (product of A=B=-32768), last on beat 512, ACC_W=40.
  - SATURATE=1 -> out_data=0x7FFFFFFFFF, out_sat=1.
  - SATURATE=0 -> out_data=0x8000000000, out_sat=0.
- Backpressure:
  - Result pending with out_ready=0, next last beat in s1 -> in_ready=0 and out_data held.
  - Raise out_ready -> old result consumed, new result loaded on the same edge with out_valid staying 1, and in_ready returns to 1.
- flush:
  - Accumulate 100, 200, then flush, then 7 with last -> out_data=0x0000000007.
  - A pending result present before the flush remains valid until out_ready.
- Async reset mid-stream: drop rst_n between beats -> all outputs 0 without a clock edge, in_ready=1 after release, next dot product starts from 0.
